// File: rtl/pixel_layer_select_pkg.sv
// pixel_pkg: shared types and constants for the palette-lookup front end.
// Scene encoding, palette select codes, and sprite/background geometry.
package pixel_pkg;

    typedef enum logic [1:0] {
        SC_START = 2'd0,
        SC_MAP   = 2'd1,
        SC_GYM   = 2'd2
    } scene_t;

    typedef enum logic [1:0] {
        SEL_SPR   = 2'd0,
        SEL_MAP   = 2'd1,
        SEL_GYM   = 2'd2,
        SEL_START = 2'd3
    } sel_t;

    localparam int unsigned SPR_W    = 32;
    localparam int unsigned BG_W     = 320;
    localparam int unsigned BG_DEPTH = 76800;

    // Background palette that a scene draws from.
    function automatic sel_t scene_sel(input scene_t s);
        case (s)
            SC_MAP:  return SEL_MAP;
            SC_GYM:  return SEL_GYM;
            default: return SEL_START;
        endcase
    endfunction

endpackage

// File: rtl/pixel_layer_select_sprite_hit.sv
// sprite_hit: combinational player-box test and sprite ROM address.
// Optional feature macro: SPRITE_FLIP_EN (horizontal mirroring of the sprite).
module sprite_hit
    import pixel_pkg::*;
#(
    parameter int unsigned SPR_FRAMES = 4
) (
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic [9:0]  player_x,
    input  logic [9:0]  player_y,
    input  logic [1:0]  frame,
    input  logic        flip,
    input  scene_t      scene,
    output logic        hit,
    output logic [11:0] spr_addr
);

    logic [10:0] dx;
    logic [10:0] dy;
    logic [4:0]  col;
    logic        in_x;
    logic        in_y;
    logic        scene_ok;
    logic        frame_ok;

    // Offsets wrap modulo 2^11, so a negative offset compares as a large
    // unsigned value and fails the < SPR_W test: no wrap-around hits.
    always_comb begin
        dx       = {1'b0, draw_x} - {1'b0, player_x};
        dy       = {1'b0, draw_y} - {1'b0, player_y};
        in_x     = dx < 11'(SPR_W);
        in_y     = dy < 11'(SPR_W);
        scene_ok = (scene == SC_MAP) || (scene == SC_GYM);
        frame_ok = 32'(frame) < SPR_FRAMES;
        hit      = in_x && in_y && scene_ok && frame_ok;
    end

`ifdef SPRITE_FLIP_EN
    // Mirrored column is 31-dx, which is the bitwise inverse of the 5-bit dx.
    always_comb begin
        col = flip ? ~dx[4:0] : dx[4:0];
    end
`else
    logic unused_flip;
    assign unused_flip = flip;

    // Column is the plain horizontal offset into the box.
    always_comb begin
        col = dx[4:0];
    end
`endif

    // frame*1024 + dy*32 + col, held at zero outside the box.
    always_comb begin
        spr_addr = hit ? {frame, dy[4:0], col} : '0;
    end

endmodule

// File: rtl/pixel_layer_select.sv
// pixel_layer_select: scan coordinates -> ROM addresses -> palette select/indices.
// Two-strobe pipeline (address stage, ROM-capture stage) plus the scene register.
// Optional feature macro: SPRITE_FLIP_EN (handled inside sprite_hit).
module pixel_layer_select
    import pixel_pkg::*;
#(
    parameter int unsigned SPR_FRAMES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pix_en,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic [1:0]  scene_req,
    input  logic [9:0]  player_x,
    input  logic [9:0]  player_y,
    input  logic [1:0]  player_frame,
    input  logic        player_flip,
    output logic [16:0] bg_addr,
    output logic [11:0] spr_addr,
    input  logic [7:0]  map_idx,
    input  logic [5:0]  gym_idx,
    input  logic [4:0]  start_idx,
    input  logic [3:0]  spr_idx,
    output logic [1:0]  select,
    output logic [3:0]  palette_color,
    output logic [7:0]  map_palette_color,
    output logic [5:0]  gym_palette_color,
    output logic [4:0]  start_palette_color,
    output logic        out_blank,
    output logic [1:0]  scene
);

    scene_t      scene_q;
    scene_t      scene_nxt;
    logic        hit_nxt;
    logic [11:0] spr_nxt;
    logic [16:0] bg_nxt;

    logic        hit_a;
    logic        blank_a;
    scene_t      scene_a;

    sel_t        sel_q;
    sel_t        sel_nxt;
    logic [3:0]  pc_nxt;
    logic [7:0]  mc_nxt;
    logic [5:0]  gc_nxt;
    logic [4:0]  sc_nxt;

    assign scene  = scene_q;
    assign select = sel_q;

    // Scene request is honoured only on the frame-start strobe; code 3 is ignored.
    always_comb begin
        scene_nxt = scene_q;
        if (pix_en && (DrawX == '0) && (DrawY == '0) && (scene_req != 2'd3)) begin
            scene_nxt = scene_t'(scene_req);
        end
    end

    // Scene register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            scene_q <= SC_START;
        end else begin
            scene_q <= scene_nxt;
        end
    end

    // Stage A uses scene_nxt so the (0,0) pixel already carries the new scene.
    sprite_hit #(
        .SPR_FRAMES (SPR_FRAMES)
    ) u_sprite_hit (
        .draw_x   (DrawX),
        .draw_y   (DrawY),
        .player_x (player_x),
        .player_y (player_y),
        .frame    (player_frame),
        .flip     (player_flip),
        .scene    (scene_nxt),
        .hit      (hit_nxt),
        .spr_addr (spr_nxt)
    );

    // Background address on the half-resolution 320-wide grid.
    always_comb begin
        bg_nxt = 17'(DrawY[9:1]) * 17'(BG_W) + 17'(DrawX[9:1]);
    end

    // Stage A: register ROM addresses and the per-pixel side information.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bg_addr  <= '0;
            spr_addr <= '0;
            hit_a    <= 1'b0;
            blank_a  <= 1'b0;
            scene_a  <= SC_START;
        end else if (pix_en) begin
            bg_addr  <= bg_nxt;
            spr_addr <= spr_nxt;
            hit_a    <= hit_nxt;
            blank_a  <= blank;
            scene_a  <= scene_nxt;
        end
    end

    // Stage B decode: opaque sprite wins, otherwise the scene background.
    always_comb begin
        sel_nxt = scene_sel(scene_a);
        pc_nxt  = '0;
        mc_nxt  = '0;
        gc_nxt  = '0;
        sc_nxt  = '0;
        if (blank_a) begin
            if (hit_a && (spr_idx != '0)) begin
                sel_nxt = SEL_SPR;
                pc_nxt  = spr_idx;
            end else begin
                case (scene_a)
                    SC_MAP:  mc_nxt = map_idx;
                    SC_GYM:  gc_nxt = gym_idx;
                    default: sc_nxt = start_idx;
                endcase
            end
        end
    end

    // Stage B: capture ROM data into the palette outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_q               <= SEL_START;
            palette_color       <= '0;
            map_palette_color   <= '0;
            gym_palette_color   <= '0;
            start_palette_color <= '0;
            out_blank           <= 1'b0;
        end else if (pix_en) begin
            sel_q               <= sel_nxt;
            palette_color       <= pc_nxt;
            map_palette_color   <= mc_nxt;
            gym_palette_color   <= gc_nxt;
            start_palette_color <= sc_nxt;
            out_blank           <= blank_a;
        end
    end

endmodule
